// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: shadow stage slot, FSM states,
// forwarding select encoding and the slot match helper.
package pipe_ctrl_pkg;

    // Slot destinations are stored at a fixed width; REG_ADDR_W must not exceed it.
    localparam int SLOT_ADDR_W = 8;

    typedef struct packed {
        logic                   valid;
        logic [SLOT_ADDR_W-1:0] dst;
        logic                   wr;
        logic                   is_mul;
    } stage_slot_t;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        MUL_BUSY = 2'd2
    } fsm_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 2'd0;
    localparam fwd_sel_t FWD_EX = 2'd1;
    localparam fwd_sel_t FWD_WB = 2'd2;

    // A multiply still occupying Execute has no result yet, so it cannot source a forward.
    function automatic logic slot_hits(stage_slot_t slot, logic [SLOT_ADDR_W-1:0] src,
                                       logic mul_busy);
        return slot.valid && slot.wr && !(slot.is_mul && mul_busy) && (slot.dst == src);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-source operand forwarding select: EX result beats WB result, register 0 never forwards.
module fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  used_i,
    input  stage_slot_t           ex_slot_i,
    input  stage_slot_t           wb_slot_i,
    input  logic                  mul_busy_i,
    output fwd_sel_t              sel_o
);

    logic [SLOT_ADDR_W-1:0] src_ext;

    always_comb begin
        src_ext = SLOT_ADDR_W'(src_i);
        sel_o   = FWD_RF;
        if (used_i && (src_i != '0)) begin
            if (slot_hits(ex_slot_i, src_ext, mul_busy_i)) begin
                sel_o = FWD_EX;
            end else if (slot_hits(wb_slot_i, src_ext, 1'b0)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Sequencing controller for the Decode -> Execute -> WriteBack pipeline: reset hold,
// multiply stalls, and a shadow EX/WB scoreboard driving operand forwarding.
module pipeline_hazard_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 4,
    parameter int MUL_LATENCY = 3,
    parameter int RESET_HOLD  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src_a,
    input  logic [REG_ADDR_W-1:0] id_src_b,
    input  logic                  id_src_a_used,
    input  logic                  id_src_b_used,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_wr_en,
    input  logic                  id_is_mul,
    output logic                  internal_reset,
    output logic                  stalled,
    output logic                  issue,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel
);

    localparam int HOLD_W = $clog2(RESET_HOLD + 1);
    localparam int MUL_W  = $clog2(MUL_LATENCY + 1);

    fsm_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [MUL_W-1:0]  mul_q, mul_d;
    stage_slot_t       ex_q, ex_d;
    stage_slot_t       wb_q, wb_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RST_HOLD;
            hold_q  <= HOLD_W'(RESET_HOLD);
            mul_q   <= '0;
            ex_q    <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            mul_q   <= mul_d;
            ex_q    <= ex_d;
            wb_q    <= wb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        mul_d   = mul_q;
        ex_d    = ex_q;
        wb_d    = wb_q;

        if (stalled) begin
            wb_d = '0;
        end else begin
            wb_d = ex_q;
            ex_d = issue ? '{valid: 1'b1, dst: SLOT_ADDR_W'(id_dst),
                             wr: id_wr_en, is_mul: id_is_mul} : '0;
        end

        case (state_q)
            RST_HOLD: begin
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            RUN: begin
                if (issue && id_is_mul && (MUL_LATENCY > 1)) begin
                    state_d = MUL_BUSY;
                    mul_d   = MUL_W'(MUL_LATENCY - 1);
                end
            end
            MUL_BUSY: begin
                mul_d = mul_q - MUL_W'(1);
                if (mul_q <= MUL_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: state_d = RST_HOLD;
        endcase
    end

    // Reset gates the state-derived outputs so the reset cycle itself looks like a hold cycle.
    always_comb begin
        internal_reset = reset || (state_q == RST_HOLD);
        stalled        = !reset && (state_q == MUL_BUSY);
        issue          = id_valid && !stalled && !internal_reset;
    end

    logic [REG_ADDR_W-1:0] src_arr  [2];
    logic                  used_arr [2];
    fwd_sel_t              sel_arr  [2];

    assign src_arr[0]  = id_src_a;
    assign src_arr[1]  = id_src_b;
    assign used_arr[0] = id_src_a_used;
    assign used_arr[1] = id_src_b_used;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_select #(
                .REG_ADDR_W(REG_ADDR_W)
            ) u_fwd_select (
                .src_i      (src_arr[gi]),
                .used_i     (used_arr[gi]),
                .ex_slot_i  (ex_q),
                .wb_slot_i  (wb_q),
                .mul_busy_i (stalled),
                .sel_o      (sel_arr[gi])
            );
        end
    endgenerate

    assign fwd_a_sel = internal_reset ? FWD_RF : sel_arr[0];
    assign fwd_b_sel = internal_reset ? FWD_RF : sel_arr[1];

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Drives a MUL_LATENCY=3 and a MUL_LATENCY=1 controller with the same instruction stream
// and compares both against a cycle-level model of the pipeline contents.
module tb_pipeline_hazard_controller;

    localparam int RESET_HOLD = 2;
    localparam int LAT [2] = '{3, 1};

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [3:0] id_src_a, id_src_b, id_dst;
    logic       id_src_a_used, id_src_b_used, id_wr_en, id_is_mul;

    logic       ir_w   [2];
    logic       st_w   [2];
    logic       is_w   [2];
    logic [1:0] fa_w   [2];
    logic [1:0] fb_w   [2];

    int checks = 0;
    int errors = 0;

    // Model of what sits in each stage: remaining reset-hold and stall cycles,
    // and the destination record of the instruction in EX and in WB.
    int m_hold  [2];
    int m_stall [2];
    bit ex_v [2], ex_w [2], wb_v [2], wb_w [2];
    int ex_d [2], wb_d [2];

    always #5 clock = ~clock;

    pipeline_hazard_controller #(.REG_ADDR_W(4), .MUL_LATENCY(3), .RESET_HOLD(RESET_HOLD)) u_dut3 (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_src_a(id_src_a), .id_src_b(id_src_b),
        .id_src_a_used(id_src_a_used), .id_src_b_used(id_src_b_used),
        .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_mul(id_is_mul),
        .internal_reset(ir_w[0]), .stalled(st_w[0]), .issue(is_w[0]),
        .fwd_a_sel(fa_w[0]), .fwd_b_sel(fb_w[0])
    );

    pipeline_hazard_controller #(.REG_ADDR_W(4), .MUL_LATENCY(1), .RESET_HOLD(RESET_HOLD)) u_dut1 (
        .clock(clock), .reset(reset), .id_valid(id_valid),
        .id_src_a(id_src_a), .id_src_b(id_src_b),
        .id_src_a_used(id_src_a_used), .id_src_b_used(id_src_b_used),
        .id_dst(id_dst), .id_wr_en(id_wr_en), .id_is_mul(id_is_mul),
        .internal_reset(ir_w[1]), .stalled(st_w[1]), .issue(is_w[1]),
        .fwd_a_sel(fa_w[1]), .fwd_b_sel(fb_w[1])
    );

    // Newest in-flight writer of src wins; register 0 never forwards.
    function automatic logic [1:0] m_fwd(int k, bit used, int src);
        if (!used || src == 0) return 2'd0;
        if (ex_v[k] && ex_w[k] && ex_d[k] == src) return 2'd1;
        if (wb_v[k] && wb_w[k] && wb_d[k] == src) return 2'd2;
        return 2'd0;
    endfunction

    task automatic chk(string tag, int k, logic [1:0] got, logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s lat%0d: got %0d expected %0d", tag, LAT[k], got, exp);
        end
    endtask

    task automatic step(bit rst, bit v, int a, int b, bit ua, bit ub, int dst, bit wr, bit mul);
        bit iss [2];
        @(negedge clock);
        reset = rst; id_valid = v;
        id_src_a = 4'(a); id_src_b = 4'(b);
        id_src_a_used = ua; id_src_b_used = ub;
        id_dst = 4'(dst); id_wr_en = wr; id_is_mul = mul;
        #1;
        for (int k = 0; k < 2; k++) begin
            bit e_ir, e_st, e_is;
            e_ir = rst || (m_hold[k] > 0);
            e_st = !rst && (m_stall[k] > 0);
            e_is = v && !e_st && !e_ir;
            chk("internal_reset", k, {1'b0, ir_w[k]}, {1'b0, e_ir});
            chk("stalled",        k, {1'b0, st_w[k]}, {1'b0, e_st});
            chk("issue",          k, {1'b0, is_w[k]}, {1'b0, e_is});
            if (!e_st) begin
                chk("fwd_a_sel", k, fa_w[k], e_ir ? 2'd0 : m_fwd(k, ua, a));
                chk("fwd_b_sel", k, fb_w[k], e_ir ? 2'd0 : m_fwd(k, ub, b));
            end
            iss[k] = e_is;
        end
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_hold[k] = RESET_HOLD; m_stall[k] = 0; ex_v[k] = 0; wb_v[k] = 0;
            end else begin
                if (m_hold[k] > 0) m_hold[k]--;
                if (m_stall[k] > 0) begin
                    m_stall[k]--;
                    wb_v[k] = 0;
                end else begin
                    wb_v[k] = ex_v[k]; wb_w[k] = ex_w[k]; wb_d[k] = ex_d[k];
                    ex_v[k] = iss[k];  ex_w[k] = wr;      ex_d[k] = dst;
                    if (iss[k] && mul && LAT[k] > 1) m_stall[k] = LAT[k] - 1;
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_hold[k] = RESET_HOLD; m_stall[k] = 0;
            ex_v[k] = 0; ex_w[k] = 0; ex_d[k] = 0;
            wb_v[k] = 0; wb_w[k] = 0; wb_d[k] = 0;
        end
        reset = 1'b1; id_valid = 1'b0; id_src_a = '0; id_src_b = '0;
        id_src_a_used = 1'b0; id_src_b_used = 1'b0; id_dst = '0; id_wr_en = 1'b0; id_is_mul = 1'b0;

        // Reset for 3 cycles with a valid instruction offered, then the hold window.
        repeat (3) step(1, 1, 0, 0, 0, 0, 1, 1, 0);
        repeat (2) step(0, 1, 0, 0, 0, 0, 1, 1, 0);
        $display("reset sequencing done: %0d checks so far", checks);

        // EX then WB forwarding of r3.
        step(0, 1, 0, 0, 0, 0, 3, 1, 0);
        step(0, 1, 3, 0, 1, 0, 7, 1, 0);
        step(0, 1, 3, 0, 1, 0, 0, 0, 0);
        $display("ex/wb forwarding steps done");

        // Back-to-back writes of r5 (EX wins), then r0 never forwards.
        step(0, 1, 0, 0, 0, 0, 5, 1, 0);
        step(0, 1, 0, 0, 0, 0, 5, 1, 0);
        step(0, 1, 1, 5, 1, 1, 6, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 1, 0, 0, 0);
        $display("priority and r0 steps done");

        // Multiply to r2, dependent held in Decode until it issues.
        step(0, 1, 0, 0, 0, 0, 2, 1, 1);
        repeat (3) step(0, 1, 2, 2, 1, 1, 0, 0, 0);
        step(0, 0, 2, 0, 1, 0, 0, 0, 0);
        $display("multiply stall steps done");

        // Reset during the first multiply stall cycle clears everything in flight.
        step(0, 1, 0, 0, 0, 0, 4, 1, 1);
        step(1, 1, 4, 4, 1, 1, 0, 0, 0);
        repeat (2) step(0, 1, 4, 4, 1, 1, 0, 0, 0);
        step(0, 1, 4, 4, 1, 1, 0, 0, 0);
        $display("reset during multiply steps done");

        // Randomized instruction stream with occasional resets.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 80,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) < 20);
        end
        $display("random stream done: %0d checks so far", checks);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
